// File: rtl/player_collision_frame_if.sv
// Pixel-cycle bus between the bitmap stages and the per-frame collision accumulator.
// master = upstream bitmap/video side, slave = player_collision_frame.
interface player_collision_frame_if;
  logic       startOfFrame;
  logic       playerDrawingRequest;
  logic [3:0] HitEdgeCode;
  logic       wallDrawingRequest;
  logic       hazardDrawingRequest;
  logic       itemDrawingRequest;
  logic [3:0] collisionEdges;
  logic       hazardHit;
  logic       itemHit;
  logic       frameValid;

  modport master (
    output startOfFrame, playerDrawingRequest, HitEdgeCode,
           wallDrawingRequest, hazardDrawingRequest, itemDrawingRequest,
    input  collisionEdges, hazardHit, itemHit, frameValid
  );

  modport slave (
    input  startOfFrame, playerDrawingRequest, HitEdgeCode,
           wallDrawingRequest, hazardDrawingRequest, itemDrawingRequest,
    output collisionEdges, hazardHit, itemHit, frameValid
  );
endinterface

// File: rtl/player_collision_frame.sv
// Per-frame player overlap accumulator: counts wall overlap per edge plus hazard/item overlap,
// publishes results at each startOfFrame. PLAYER_COLLISION_THRESHOLD_EN enables CNT_W-bit
// counters with MIN_HIT_PIXELS threshold; otherwise 1-bit sticky flags (threshold 1).
module player_collision_frame #(
  parameter int MIN_HIT_PIXELS = 2,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  player_collision_frame_if.slave   bus
);
`ifdef PLAYER_COLLISION_THRESHOLD_EN
  localparam int CW  = CNT_W;
  localparam int THR = MIN_HIT_PIXELS;
`else
  localparam int CW  = 1;
  localparam int THR = 1;
`endif

  localparam logic [0:0] SYNC  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]          state;
  logic [3:0][CW-1:0]  edge_cnt;
  logic [CW-1:0]       haz_cnt;
  logic                item_seen;
  logic [3:0]          edges_q;
  logic                haz_q, item_q, fv_q;

  logic       wall_ov, haz_inc, item_inc;
  logic [3:0] edge_inc;

  always_comb begin
    wall_ov  = bus.playerDrawingRequest & bus.wallDrawingRequest;
    edge_inc = {4{wall_ov}} & bus.HitEdgeCode;
    haz_inc  = bus.playerDrawingRequest & bus.hazardDrawingRequest;
    item_inc = bus.playerDrawingRequest & bus.itemDrawingRequest;
  end

  // With CW=1 this degenerates to a sticky flag, so both build modes share one path.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic inc);
    return (inc && (c != {CW{1'b1}})) ? c + CW'(1) : c;
  endfunction

  function automatic logic hit(input logic [CW-1:0] c);
    return int'(c) >= THR;
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= SYNC;
      edge_cnt  <= '0;
      haz_cnt   <= '0;
      item_seen <= 1'b0;
      edges_q   <= 4'b0000;
      haz_q     <= 1'b0;
      item_q    <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      haz_q  <= 1'b0;
      item_q <= 1'b0;
      if (bus.startOfFrame) begin
        state <= ACCUM;
        if (state == ACCUM) begin
          for (int i = 0; i < 4; i++) edges_q[i] <= hit(edge_cnt[i]);
          haz_q  <= hit(haz_cnt);
          item_q <= item_seen;
          fv_q   <= 1'b1;
        end
        // SOF pixel is the first pixel of the new frame, so load rather than clear.
        for (int i = 0; i < 4; i++) edge_cnt[i] <= CW'(edge_inc[i]);
        haz_cnt   <= CW'(haz_inc);
        item_seen <= item_inc;
      end else if (state == ACCUM) begin
        for (int i = 0; i < 4; i++) edge_cnt[i] <= sat_inc(edge_cnt[i], edge_inc[i]);
        haz_cnt   <= sat_inc(haz_cnt, haz_inc);
        item_seen <= item_seen | item_inc;
      end
    end
  end

  assign bus.collisionEdges = edges_q;
  assign bus.hazardHit      = haz_q;
  assign bus.itemHit        = item_q;
  assign bus.frameValid     = fv_q;
endmodule

// File: tb/tb_player_collision_frame.sv
// Self-checking bench for player_collision_frame: directed scenarios plus random pixel streams
// checked against a frame-level reference model.
module tb_player_collision_frame;
  localparam int MIN_HIT = 2;
  localparam int CNT_W   = 8;
`ifdef PLAYER_COLLISION_THRESHOLD_EN
  localparam int THR = MIN_HIT;
`else
  localparam int THR = 1;
`endif

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  player_collision_frame_if bus();

  player_collision_frame #(.MIN_HIT_PIXELS(MIN_HIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded per-frame tallies; saturation is invisible at the outputs
  // as long as the threshold fits in the counter range.
  bit         m_accum;
  int         m_edge[4];
  int         m_haz;
  bit         m_item;
  logic [3:0] e_edges;
  logic       e_haz, e_item, e_fv;

  task automatic m_reset();
    m_accum = 0;
    for (int i = 0; i < 4; i++) m_edge[i] = 0;
    m_haz = 0; m_item = 0;
    e_edges = 4'b0000; e_haz = 0; e_item = 0; e_fv = 0;
  endtask

  // Called at a negedge; drives one pixel, updates the model at the posedge, returns at next negedge.
  task automatic drive(input bit sof, input bit p, input logic [3:0] code,
                       input bit w, input bit h, input bit it);
    bus.startOfFrame         = sof;
    bus.playerDrawingRequest = p;
    bus.HitEdgeCode          = code;
    bus.wallDrawingRequest   = w;
    bus.hazardDrawingRequest = h;
    bus.itemDrawingRequest   = it;
    @(posedge clk);
    e_haz = 0; e_item = 0;
    if (sof) begin
      if (m_accum) begin
        for (int i = 0; i < 4; i++) e_edges[i] = (m_edge[i] >= THR);
        e_haz  = (m_haz >= THR);
        e_item = m_item;
        e_fv   = 1;
      end
      m_accum = 1;
      for (int i = 0; i < 4; i++) m_edge[i] = (p && w && code[i]) ? 1 : 0;
      m_haz  = (p && h) ? 1 : 0;
      m_item = p && it;
    end else if (m_accum) begin
      for (int i = 0; i < 4; i++) if (p && w && code[i]) m_edge[i]++;
      if (p && h)  m_haz++;
      if (p && it) m_item = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 4'b0000, 0, 0, 0);
  endtask

  task automatic sof();
    drive(1, 0, 4'b0000, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.startOfFrame = 0; bus.playerDrawingRequest = 0; bus.HitEdgeCode = 4'b0000;
    bus.wallDrawingRequest = 0; bus.hazardDrawingRequest = 0; bus.itemDrawingRequest = 0;
    resetN = 0;
    m_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b",
               {bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid}, 7'b0);
    end
    resetN = 1;
    @(negedge clk);
  endtask

  task automatic test_sync_ignore();
    for (int k = 0; k < 3; k++) drive(0, 1, 4'b0001, 1, 0, 0);
    sof();
    checks++;
    if (bus.frameValid !== 1'b0) begin
      errors++; $display("FAIL sync_first_sof_fv got=%b exp=0", bus.frameValid);
    end
    idle(5);
    sof();
    checks++;
    if (bus.collisionEdges !== 4'b0000) begin
      errors++; $display("FAIL sync_ignored_edges got=%b exp=0000", bus.collisionEdges);
    end
    checks++;
    if (bus.frameValid !== 1'b1) begin
      errors++; $display("FAIL sync_fv got=%b exp=1", bus.frameValid);
    end
  endtask

  task automatic test_threshold();
    drive(0, 1, 4'b0001, 1, 0, 0);
    drive(0, 1, 4'b0001, 1, 0, 0);
    drive(0, 1, 4'b1000, 1, 0, 0);
    idle(2);
    sof();
    checks++;
    if (bus.collisionEdges !== e_edges) begin
      errors++; $display("FAIL threshold_edges got=%b exp=%b", bus.collisionEdges, e_edges);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 4'b0010, 1, 0, 0);
      checks++;
      if (bus.collisionEdges !== e_edges) begin
        errors++; $display("FAIL edges_hold cyc=%0d got=%b exp=%b", k, bus.collisionEdges, e_edges);
      end
    end
  endtask

  task automatic test_corner();
    sof();
    drive(0, 1, 4'b1100, 1, 0, 0);
    drive(0, 1, 4'b1100, 1, 0, 0);
    sof();
    checks++;
    if (bus.collisionEdges !== 4'b1100) begin
      errors++; $display("FAIL corner_edges got=%b exp=1100", bus.collisionEdges);
    end
  endtask

  task automatic test_haz_item();
    drive(0, 1, 4'b0000, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 1);
    sof();
    checks++;
    if (bus.hazardHit !== ((THR <= 1) ? 1'b1 : 1'b0)) begin
      errors++; $display("FAIL hazard_single got=%b exp=%b", bus.hazardHit, (THR <= 1));
    end
    checks++;
    if (bus.itemHit !== 1'b1) begin
      errors++; $display("FAIL item_pulse got=%b exp=1", bus.itemHit);
    end
    idle(1);
    checks++;
    if ({bus.hazardHit, bus.itemHit} !== 2'b00) begin
      errors++; $display("FAIL pulse_width got=%b exp=00", {bus.hazardHit, bus.itemHit});
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) drive(0, 1, 4'b0100, 1, 0, 0);
    sof();
    checks++;
    if (bus.collisionEdges !== 4'b0100) begin
      errors++; $display("FAIL saturate_300 got=%b exp=0100", bus.collisionEdges);
    end
    // 257 would wrap to 1 (below threshold) without saturation
    for (int k = 0; k < 257; k++) drive(0, 1, 4'b0100, 1, 0, 0);
    sof();
    checks++;
    if (bus.collisionEdges[2] !== 1'b1) begin
      errors++; $display("FAIL saturate_257 got=%b exp=1", bus.collisionEdges[2]);
    end
  endtask

  task automatic test_sof_pixel_and_back_to_back();
    drive(1, 1, 4'b0001, 1, 0, 0);
    drive(0, 1, 4'b0001, 1, 0, 0);
    sof();
    checks++;
    if (bus.collisionEdges !== 4'b0001) begin
      errors++; $display("FAIL sof_pixel_counted got=%b exp=0001", bus.collisionEdges);
    end
    drive(1, 1, 4'b0000, 0, 1, 1);
    checks++;
    if (bus.collisionEdges !== e_edges) begin
      errors++; $display("FAIL b2b_first got=%b exp=%b", bus.collisionEdges, e_edges);
    end
    sof();
    checks++;
    if ({bus.hazardHit, bus.itemHit} !== {((THR <= 1) ? 1'b1 : 1'b0), 1'b1}) begin
      errors++; $display("FAIL b2b_one_pixel_frame got=%b exp=%b%b",
                         {bus.hazardHit, bus.itemHit}, (THR <= 1), 1'b1);
    end
    checks++;
    if (bus.collisionEdges !== 4'b0000) begin
      errors++; $display("FAIL b2b_edges got=%b exp=0000", bus.collisionEdges);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 4'b0001, 1, 0, 0);
    drive(0, 1, 4'b0001, 1, 0, 0);
    sof();
    drive(0, 1, 4'b0010, 1, 1, 1);
    drive(0, 1, 4'b0010, 1, 1, 1);
    resetN = 0;
    #1;
    checks++;
    if ({bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b",
               {bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid}, 7'b0);
    end
    m_reset();
    @(negedge clk);
    resetN = 1;
    drive(0, 1, 4'b0001, 1, 1, 1);
    sof();
    checks++;
    if ({bus.frameValid, bus.hazardHit, bus.itemHit} !== 3'b000) begin
      errors++; $display("FAIL reset_resync got=%b exp=000",
                         {bus.frameValid, bus.hazardHit, bus.itemHit});
    end
    drive(0, 1, 4'b0001, 1, 0, 0);
    drive(0, 1, 4'b0001, 1, 0, 0);
    sof();
    checks++;
    if ({bus.frameValid, bus.collisionEdges} !== 5'b10001) begin
      errors++; $display("FAIL reset_first_frame got=%b exp=10001",
                         {bus.frameValid, bus.collisionEdges});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      bit s;
      s = ($urandom_range(0, 39) == 0) || (k > 1500 && k < 1520 && $urandom_range(0, 1) == 1);
      drive(s, 1'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      checks++;
      if ({bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid} !==
          {e_edges, e_haz, e_item, e_fv}) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", k,
                 {bus.collisionEdges, bus.hazardHit, bus.itemHit, bus.frameValid},
                 {e_edges, e_haz, e_item, e_fv});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_ignore();
    test_threshold();
    test_corner();
    test_haz_item();
    test_saturate();
    test_sof_pixel_and_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/player_collision_frame.md
# player_collision_frame

Per-frame collision accumulator sitting directly downstream of the player bitmap stage. It consumes the player's registered drawingRequest and HitEdgeCode, together with the wall, hazard and item drawing requests produced by the other bitmap stages in the same pixel cycle. Over each video frame it counts overlapping pixels per player edge. At the next frame start it publishes stable per-edge collision flags plus one-cycle hazard/item event pulses for the game-control logic.

## Interface
- MIN_HIT_PIXELS, 2: overlap pixels (1..255) required in one frame before an edge, or the hazard, counts as hit.
- CNT_W, 8: width of each saturating overlap counter.

- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse on the first pixel (0,0) of every frame
- playerDrawingRequest  in  1  player bitmap drawing request, registered, same pixel as the other requests
- HitEdgeCode  in  4  player edge code {Left,Top,Right,Bottom}; corners carry two bits
- wallDrawingRequest  in  1  wall/tile bitmap drawing request, pixel-aligned
- hazardDrawingRequest  in  1  hazard (fire/water) drawing request, pixel-aligned
- itemDrawingRequest  in  1  collectible drawing request, pixel-aligned
- collisionEdges  out  4  per-edge wall collision flags {L,T,R,B} for the previous frame, held all frame
- hazardHit  out  1  one-cycle pulse: player overlapped a hazard last frame
- itemHit  out  1  one-cycle pulse: player overlapped an item last frame
- frameValid  out  1  high once at least one complete frame has been evaluated

## Operation
- States: SYNC (after reset) and ACCUM.
- SYNC:
  - All inputs are ignored except startOfFrame.
  - On startOfFrame, move to ACCUM and load the counters with that cycle's contribution.
  - No outputs change.
- ACCUM, non-SOF cycle:
  - wallOv = playerDrawingRequest & wallDrawingRequest. For each i with wallOv & HitEdgeCode[i], edgeCnt[i] += 1.
  - hazOv = player & hazard: hazCnt += 1.
  - itemOv = player & item: itemSeen <= 1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- ACCUM, startOfFrame cycle (evaluation):
  - collisionEdges[i] <= (edgeCnt[i] >= MIN_HIT_PIXELS).
  - hazardHit <= (hazCnt >= MIN_HIT_PIXELS).
  - itemHit <= itemSeen.
  - frameValid <= 1.
  - Evaluation uses counts accumulated before this cycle. The SOF-cycle pixel belongs to the new frame: counters and itemSeen load that cycle's contribution (0 or 1) instead of clearing to 0.
- Player pixels with HitEdgeCode = 0 increment no edge counter, but still count toward hazard and item.
- Simultaneous wall, hazard and item overlap on one pixel: all three are accounted independently.
- Opposite-edge bits set in the same frame are reported as-is, with no arbitration.

## Timing
- Reset values: collisionEdges 4'b0000, hazardHit 0, itemHit 0, frameValid 0. All counters 0, itemSeen 0, state SYNC.
- Reset is asynchronous at any point, including mid-frame. After release the block waits in SYNC for the next startOfFrame. The first valid results appear one frame after that.
- Latency: outputs update on the clock edge that samples startOfFrame, so they are visible the cycle after the SOF pulse.
- collisionEdges holds until the next evaluation.
- hazardHit/itemHit are high for exactly that one cycle, then return to 0.
- Two startOfFrame pulses one cycle apart:
  - The second evaluates a one-pixel frame.
  - The pulses are re-evaluated, with no merging.

## Configuration
- PLAYER_COLLISION_THRESHOLD_EN defined:
  - MIN_HIT_PIXELS thresholds apply to edges and hazard, as above.
  - Counters are CNT_W bits.
- Not defined:
  - MIN_HIT_PIXELS is ignored and the threshold is effectively 1.
  - Each counter reduces to a 1-bit sticky flag.
  - Any single overlapping pixel in a frame sets the corresponding output.

## Test plan
- Reset release, then 3 wall-overlap pixels with HitEdgeCode=4'b0001 before the first SOF -> ignored (SYNC). After two SOFs with no overlap: collisionEdges=0, frameValid=1.
- In one frame, 2 pixels with code 4'b0001 and 1 pixel with 4'b1000, all overlapping wall (threshold on), then SOF -> collisionEdges=4'b0001 on cycle SOF+1. It holds until the next SOF.
- Corner pixels with code 4'b1100 overlapping wall ×2, then SOF -> collisionEdges=4'b1100.
- 1 hazard pixel plus 1 item pixel, then SOF -> hazardHit=0 with threshold (1 with macro undefined), itemHit=1 for exactly one cycle.
- 300 wall pixels on edge Top -> counter saturates at 255, no wrap; collisionEdges[2]=1.
- Overlap pixel coincident with SOF, with resetN asserted mid-frame -> SOF pixel counted in the new frame. Reset clears all outputs immediately and the block returns to SYNC.
